// File: rtl/line_buffer_ctrl_if.sv
// Pixel-stream and line-RAM bundle shared by the line buffer controller and its environment.
// No storage; pure wiring.
// Handshakes are valid/ready on the pixel side; memory side is fire-and-forget with fixed read latency.
interface line_buffer_ctrl_if #(
  parameter int NO_RAM = 4,
  parameter int DW     = 12,
  parameter int AW     = 11
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_sof;
  logic [DW-1:0]              in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [(NO_RAM+1)*DW-1:0]   out_col;
  logic [2:0]                 out_lines;
  logic                       out_eol;
  logic [NO_RAM-1:0]          mem_wr_en;
  logic [NO_RAM*AW-1:0]       mem_wr_addr;
  logic [NO_RAM*DW-1:0]       mem_wr_data;
  logic [NO_RAM-1:0]          mem_rd_en;
  logic [NO_RAM*AW-1:0]       mem_rd_addr;
  logic [NO_RAM*DW-1:0]       mem_rd_data;

  // Controller side: consumes pixels, produces columns, drives the RAM wrapper.
  modport master (
    input  in_valid, in_sof, in_data, out_ready, mem_rd_data,
    output in_ready, out_valid, out_col, out_lines, out_eol,
    output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
  );

  // Environment side: pixel source, column sink and the RAM wrapper.
  modport slave (
    output in_valid, in_sof, in_data, out_ready, mem_rd_data,
    input  in_ready, out_valid, out_col, out_lines, out_eol,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Line buffer controller: writes each line into a rotating RAM and emits pixel + previous NO_RAM lines as a column.
// Latency: 2 cycles from accept to out_valid when the output FIFO is empty.
// Backpressure: credit check on in_ready keeps the stage-1 pixel plus the 2-entry output FIFO from overflowing.
module line_buffer_ctrl #(
  parameter int NO_RAM = 4,
  parameter int DW     = 12,
  parameter int AW     = 11,
  parameter int IMG_W  = 1920
) (
  input  logic               clk,
  input  logic               rst_n,
  line_buffer_ctrl_if.master bus
);
  localparam int WPW  = (NO_RAM > 1) ? $clog2(NO_RAM) : 1;
  localparam int COLW = (NO_RAM + 1) * DW;

  typedef struct packed {
    logic [COLW-1:0] col;
    logic [2:0]      lines;
    logic            eol;
  } col_t;

  logic            run_q, run_d;
  logic [AW-1:0]   x_q, x_d;
  logic [WPW-1:0]  wptr_q, wptr_d;
  logic [2:0]      filled_q, filled_d;
  logic            s1_vld_q, s1_vld_d;
  logic [DW-1:0]   data_s1_q, data_s1_d;
  logic [AW-1:0]   x_s1_q, x_s1_d;
  logic [WPW-1:0]  wptr_s1_q, wptr_s1_d;
  logic [2:0]      filled_s1_q, filled_s1_d;
  logic            eol_s1_q, eol_s1_d;
  col_t            ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]      cnt_q, cnt_d;

  logic            in_ready, accept, pop, push, is_eol;
  logic [1:0]      cnt_after_pop;
  logic [AW-1:0]   x_eff;
  logic [WPW-1:0]  wptr_eff;
  logic [2:0]      filled_eff;
  col_t            col_new;

  // A start-of-frame pixel is processed as if the counters had just been cleared.
  assign x_eff      = bus.in_sof ? '0 : x_q;
  assign wptr_eff   = bus.in_sof ? '0 : wptr_q;
  assign filled_eff = bus.in_sof ? '0 : filled_q;
  assign is_eol     = (x_eff == AW'(IMG_W - 1));

  // Occupancy is taken after this cycle's pop so a full-rate stream is not throttled.
  assign pop           = (cnt_q != 2'd0) && bus.out_ready;
  assign push          = s1_vld_q;
  assign cnt_after_pop = cnt_q - {1'b0, pop};
  assign in_ready      = run_q && (({1'b0, cnt_after_pop} + {2'b00, s1_vld_q}) <= 3'd1);
  assign accept        = bus.in_valid && in_ready;

  // Read all RAMs at the accept; the write follows one cycle later so reads always see old data.
  assign bus.in_ready    = in_ready;
  assign bus.mem_rd_en   = {NO_RAM{accept}};
  assign bus.mem_rd_addr = {NO_RAM{x_eff}};
  assign bus.mem_wr_en   = s1_vld_q ? (NO_RAM'(1) << wptr_s1_q) : '0;
  assign bus.mem_wr_addr = {NO_RAM{x_s1_q}};
  assign bus.mem_wr_data = {NO_RAM{data_s1_q}};

  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_col   = ent0_q.col;
  assign bus.out_lines = ent0_q.lines;
  assign bus.out_eol   = ent0_q.eol;

  // Position counters: column, write RAM and number of completed lines in this frame.
  always_comb begin
    run_d    = 1'b1;
    x_d      = x_q;
    wptr_d   = wptr_q;
    filled_d = filled_q;
    if (accept) begin
      if (is_eol) begin
        x_d      = '0;
        wptr_d   = (wptr_eff == WPW'(NO_RAM - 1)) ? '0 : wptr_eff + WPW'(1);
        filled_d = (filled_eff == 3'(NO_RAM)) ? filled_eff : filled_eff + 3'd1;
      end else begin
        x_d      = x_eff + AW'(1);
        wptr_d   = wptr_eff;
        filled_d = filled_eff;
      end
    end
  end

  // Stage 1 holds the accepted pixel while its RAM read is in flight.
  always_comb begin
    s1_vld_d    = accept;
    data_s1_d   = data_s1_q;
    x_s1_d      = x_s1_q;
    wptr_s1_d   = wptr_s1_q;
    filled_s1_d = filled_s1_q;
    eol_s1_d    = eol_s1_q;
    if (accept) begin
      data_s1_d   = bus.in_data;
      x_s1_d      = x_eff;
      wptr_s1_d   = wptr_eff;
      filled_s1_d = filled_eff;
      eol_s1_d    = is_eol;
    end
  end

  // Column assembly: slice k comes from the RAM written k lines ago, masked until that line exists.
  always_comb begin
    int idx;
    idx              = 0;
    col_new          = '0;
    col_new.col[DW-1:0] = data_s1_q;
    for (int k = 1; k <= NO_RAM; k++) begin
      idx = (int'(wptr_s1_q) + NO_RAM - k) % NO_RAM;
      if (k <= int'(filled_s1_q)) begin
        col_new.col[k*DW +: DW] = bus.mem_rd_data[idx*DW +: DW];
      end
    end
    col_new.lines = filled_s1_q;
    col_new.eol   = eol_s1_q;
  end

  // Two-entry output FIFO whose head register drives the column outputs directly.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (pop && (cnt_q == 2'd2)) begin
      ent0_d = ent1_q;
      if (push) ent1_d = col_new;
    end else if (pop) begin
      if (push) ent0_d = col_new;
    end else if (push) begin
      if (cnt_q == 2'd0) ent0_d = col_new;
      else               ent1_d = col_new;
    end
    cnt_d = cnt_q - {1'b0, pop} + {1'b0, push};
  end

  // State registers; reset drops in-flight pixels and queued columns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      x_q         <= '0;
      wptr_q      <= '0;
      filled_q    <= '0;
      s1_vld_q    <= 1'b0;
      data_s1_q   <= '0;
      x_s1_q      <= '0;
      wptr_s1_q   <= '0;
      filled_s1_q <= '0;
      eol_s1_q    <= 1'b0;
      ent0_q      <= '0;
      ent1_q      <= '0;
      cnt_q       <= '0;
    end else begin
      run_q       <= run_d;
      x_q         <= x_d;
      wptr_q      <= wptr_d;
      filled_q    <= filled_d;
      s1_vld_q    <= s1_vld_d;
      data_s1_q   <= data_s1_d;
      x_s1_q      <= x_s1_d;
      wptr_s1_q   <= wptr_s1_d;
      filled_s1_q <= filled_s1_d;
      eol_s1_q    <= eol_s1_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl with a small-image configuration and a behavioural line-history model.
// Columns are scored in order; memory write/read strobes are checked every cycle.
// Output backpressure is exercised both in fixed sequences and randomly.
module tb_line_buffer_ctrl;
  localparam int NO_RAM = 4;
  localparam int DW     = 12;
  localparam int AW     = 11;
  localparam int IMG_W  = 8;
  localparam int COLW   = (NO_RAM + 1) * DW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  line_buffer_ctrl_if #(.NO_RAM(NO_RAM), .DW(DW), .AW(AW)) bus();

  line_buffer_ctrl #(.NO_RAM(NO_RAM), .DW(DW), .AW(AW), .IMG_W(IMG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Line RAM wrapper model: 1-cycle read latency, reads return pre-write contents.
  logic [DW-1:0]        ram [NO_RAM][1<<AW];
  logic [NO_RAM*DW-1:0] rd_q;
  assign bus.mem_rd_data = rd_q;
  always @(posedge clk) begin
    for (int i = 0; i < NO_RAM; i++) begin
      if (bus.mem_rd_en[i]) rd_q[i*DW +: DW] <= ram[i][bus.mem_rd_addr[i*AW +: AW]];
      if (bus.mem_wr_en[i]) ram[i][bus.mem_wr_addr[i*AW +: AW]] <= bus.mem_wr_data[i*DW +: DW];
    end
  end

  typedef struct {
    logic [COLW-1:0] col;
    int              lines;
    bit              eol;
    int              line;
    int              x;
    bit              tag;
  } exp_t;

  typedef struct {
    int              line;
    int              x;
    logic [COLW-1:0] col;
    int              lines;
    bit              eol;
  } vec_t;

  exp_t            exp_q[$];
  logic [DW-1:0]   img [0:63][0:IMG_W-1];
  int              m_line, m_x;
  bit              pend_vld;
  logic [NO_RAM-1:0] pend_en;
  logic [AW-1:0]   pend_addr;
  logic [DW-1:0]   pend_data;
  int              pend_line, pend_x;
  bit              hold_vld;
  logic [COLW-1:0] hold_col;
  bit              last_acc, capturing, tag_next, tag_seen;
  int              tag_lines;
  logic [COLW-1:0] cap_col   [0:15][0:IMG_W-1];
  int              cap_lines [0:15][0:IMG_W-1];
  bit              cap_eol   [0:15][0:IMG_W-1];
  logic [NO_RAM-1:0] wr_seen [0:15];
  int              checks, errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [COLW-1:0] mkcol(input logic [DW-1:0] s4, s3, s2, s1, s0);
    return {s4, s3, s2, s1, s0};
  endfunction

  // Reference: column = current pixel plus the same x of up to NO_RAM earlier lines of this frame.
  task automatic model_accept(input logic [DW-1:0] d, input bit sof);
    exp_t e;
    int   filled;
    if (sof) begin
      m_line = 0;
      m_x    = 0;
    end
    filled = (m_line < NO_RAM) ? m_line : NO_RAM;
    e.col  = '0;
    e.col[DW-1:0] = d;
    for (int k = 1; k <= NO_RAM; k++)
      if (k <= filled) e.col[k*DW +: DW] = img[(m_line - k) % 64][m_x];
    e.lines = filled;
    e.eol   = (m_x == IMG_W - 1);
    e.line  = m_line;
    e.x     = m_x;
    e.tag   = tag_next;
    exp_q.push_back(e);
    img[m_line % 64][m_x] = d;
    pend_vld  = 1'b1;
    pend_en   = NO_RAM'(1) << (m_line % NO_RAM);
    pend_addr = AW'(m_x);
    pend_data = d;
    pend_line = m_line;
    pend_x    = m_x;
    m_x++;
    if (m_x == IMG_W) begin
      m_x = 0;
      m_line++;
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    pend_vld = 1'b0;
    hold_vld = 1'b0;
    m_line   = 0;
    m_x      = 0;
  endtask

  // Observes one cycle at the falling edge: strobes, held outputs, popped columns, then accepts.
  task automatic monitor();
    bit                   acc, pop;
    logic [NO_RAM*AW-1:0] ea;
    logic [NO_RAM*DW-1:0] ed;
    exp_t                 e;
    int                   ex;
    ea  = '0;
    ed  = '0;
    acc = bus.in_valid && bus.in_ready;
    pop = bus.out_valid && bus.out_ready;
    if (pend_vld) begin
      for (int i = 0; i < NO_RAM; i++) begin
        ea[i*AW +: AW] = pend_addr;
        ed[i*DW +: DW] = pend_data;
      end
      chk("wr_en", bus.mem_wr_en, pend_en);
      chk("wr_addr", bus.mem_wr_addr, ea);
      chk("wr_data", bus.mem_wr_data, ed);
      if (capturing && pend_x == 0 && pend_line < 16) wr_seen[pend_line] = bus.mem_wr_en;
    end else begin
      chk("wr_idle", bus.mem_wr_en, 0);
    end
    pend_vld = 1'b0;
    if (acc) begin
      ex = bus.in_sof ? 0 : m_x;
      for (int i = 0; i < NO_RAM; i++) ea[i*AW +: AW] = AW'(ex);
      chk("rd_en", bus.mem_rd_en, {NO_RAM{1'b1}});
      chk("rd_addr", bus.mem_rd_addr, ea);
    end else begin
      chk("rd_idle", bus.mem_rd_en, 0);
    end
    if (hold_vld) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_col", bus.out_col, hold_col);
    end
    if (pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_col: got col %0h with no column outstanding", bus.out_col);
      end else begin
        checks--;
        e = exp_q.pop_front();
        chk("col", bus.out_col, e.col);
        chk("lines", bus.out_lines, e.lines);
        chk("eol", bus.out_eol, e.eol);
        if (capturing && e.line < 16) begin
          cap_col[e.line][e.x]   = bus.out_col;
          cap_lines[e.line][e.x] = bus.out_lines;
          cap_eol[e.line][e.x]   = bus.out_eol;
        end
        if (e.tag) begin
          tag_seen  = 1'b1;
          tag_lines = bus.out_lines;
        end
      end
    end
    hold_vld = bus.out_valid && !bus.out_ready;
    hold_col = bus.out_col;
    if (acc) model_accept(bus.in_data, bus.in_sof);
    last_acc = acc;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit sof);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = sof;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 100);
    chk("send_accept", last_acc, 1);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [9];
    logic [3:0]  wr_tab [9];
    int          acc_n, n, cyc;

    vecs[0] = '{0, 0, mkcol(0, 0, 0, 0, 12'h00), 0, 1'b0};
    vecs[1] = '{0, 7, mkcol(0, 0, 0, 0, 12'h07), 0, 1'b1};
    vecs[2] = '{1, 0, mkcol(0, 0, 0, 12'h00, 12'h10), 1, 1'b0};
    vecs[3] = '{2, 5, mkcol(0, 0, 12'h05, 12'h15, 12'h25), 2, 1'b0};
    vecs[4] = '{3, 6, mkcol(0, 12'h06, 12'h16, 12'h26, 12'h36), 3, 1'b0};
    vecs[5] = '{4, 2, mkcol(12'h02, 12'h12, 12'h22, 12'h32, 12'h42), 4, 1'b0};
    vecs[6] = '{5, 3, mkcol(12'h13, 12'h23, 12'h33, 12'h43, 12'h53), 4, 1'b0};
    vecs[7] = '{5, 7, mkcol(12'h17, 12'h27, 12'h37, 12'h47, 12'h57), 4, 1'b1};
    vecs[8] = '{8, 1, mkcol(12'h41, 12'h51, 12'h61, 12'h71, 12'h81), 4, 1'b0};
    wr_tab  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    checks = 0;  errors = 0;
    capturing = 1'b0;  tag_next = 1'b0;  tag_seen = 1'b0;  tag_lines = -1;
    last_acc = 1'b0;
    reset_model();
    bus.in_valid = 1'b0;  bus.in_sof = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b0;

    // Power-on reset
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_col", bus.out_col, 0);
    chk("rst_out_lines", bus.out_lines, 0);
    chk("rst_out_eol", bus.out_eol, 0);
    chk("rst_wr_en", bus.mem_wr_en, 0);
    chk("rst_wr_addr", bus.mem_wr_addr, 0);
    chk("rst_wr_data", bus.mem_wr_data, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_rd_addr", bus.mem_rd_addr, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("ready_before_edge", bus.in_ready, 0);
    @(posedge clk);
    #1 chk("ready_after_edge", bus.in_ready, 1);

    // Nine full lines at full rate, then compare against the hand-derived vector table
    capturing     = 1'b1;
    bus.out_ready = 1'b1;
    for (int l = 0; l < 9; l++)
      for (int x = 0; x < IMG_W; x++) send(DW'(l * 16 + x), 1'b0);
    drain(4);
    capturing = 1'b0;
    for (int v = 0; v < 9; v++) begin
      chk($sformatf("vec%0d_col", v), cap_col[vecs[v].line][vecs[v].x], vecs[v].col);
      chk($sformatf("vec%0d_lines", v), cap_lines[vecs[v].line][vecs[v].x], vecs[v].lines);
      chk($sformatf("vec%0d_eol", v), cap_eol[vecs[v].line][vecs[v].x], vecs[v].eol);
    end
    for (int l = 0; l < 9; l++) chk($sformatf("wr_rot_line%0d", l), wr_seen[l], wr_tab[l]);

    // Output stalled from an idle pipeline: two pixels fit, then in_ready drops
    bus.out_ready = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(12'hA00 + acc_n);
      tick();
      if (last_acc) acc_n++;
    end
    chk("bp_accepts", acc_n, 2);
    chk("bp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    for (int x = 2; x < IMG_W; x++) send(DW'(12'hA00 + x), 1'b0);
    drain(4);
    chk("bp_drained", exp_q.size(), 0);

    // Random valid/ready over three lines
    n = 0;  cyc = 0;
    while (n < 3 * IMG_W && cyc < 2000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = DW'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (last_acc) n++;
      cyc++;
    end
    chk("rand_accepts", n, 3 * IMG_W);
    bus.out_ready = 1'b1;
    drain(6);
    chk("rand_drained", exp_q.size(), 0);

    // Start of frame in the middle of line 2
    send(12'h300, 1'b1);
    for (int i = 1; i < 2 * IMG_W + 4; i++) send(DW'(12'h300 + i), 1'b0);
    tag_next = 1'b1;
    send(12'h3F0, 1'b1);
    tag_next = 1'b0;
    chk("sof_wr_en", bus.mem_wr_en, 4'b0001);
    chk("sof_wr_addr", bus.mem_wr_addr[AW-1:0], 0);
    for (int i = 1; i < IMG_W + 3; i++) send(DW'(12'h400 + i), 1'b0);
    drain(4);
    chk("sof_col_seen", tag_seen, 1);
    chk("sof_lines", tag_lines, 0);
    chk("sof_drained", exp_q.size(), 0);

    // Asynchronous reset with pixels in flight
    bus.in_valid = 1'b1;
    bus.in_data  = 12'h555;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_wr_en", bus.mem_wr_en, 0);
    reset_model();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 chk("midrst_wr_en_held", bus.mem_wr_en, 0);
    rst_n = 1'b1;
    #1 chk("midrst_ready_before_edge", bus.in_ready, 0);
    @(posedge clk);
    #1 chk("midrst_ready_after_edge", bus.in_ready, 1);
    for (int x = 0; x < IMG_W; x++) send(DW'(12'h600 + x), 1'b0);
    drain(4);
    chk("midrst_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
